// File: rtl/clint_timer.sv
// Core-local timer: mtime/mtimecmp/msip behind a single-beat valid/ready bus, with a one-deep response buffer.
// Define CLINT_MSIP_EN to implement the msip register and the software-interrupt output.
module clint_timer #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mtime_bigger_mtimecmp,
   output logic        sw_interrupt
);

   localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [63:0]      OFF_MSIP = 64'h0000;
   localparam logic [63:0]      OFF_CMP  = 64'h4000;
   localparam logic [63:0]      OFF_TIME = 64'hBFF8;

   logic [63:0]      mtime;
   logic [63:0]      mtimecmp;
   logic [63:0]      mtime_next;
   logic [63:0]      mtimecmp_next;
   logic [63:0]      offset;
   logic [63:0]      byte_mask;
   logic [63:0]      read_data;
   logic [PRE_W-1:0] prescaler;
   logic [PRE_W-1:0] prescaler_next;
   logic             tick;
   logic             accept;
   logic             misaligned;
   logic             sel_msip;
   logic             sel_cmp;
   logic             sel_time;
   logic             addr_err;
   logic             do_write;

`ifdef CLINT_MSIP_EN
   logic msip;
   logic msip_next;
`endif

   assign req_ready = ~resp_valid | resp_ready;
   assign accept    = req_valid & req_ready;

   always_comb begin
      offset     = req_addr - BASE_ADDR;
      misaligned = |req_addr[2:0];
      sel_msip   = (offset == OFF_MSIP);
      sel_cmp    = (offset == OFF_CMP);
      sel_time   = (offset == OFF_TIME);
      addr_err   = misaligned | ~(sel_msip | sel_cmp | sel_time);
      do_write   = accept & req_wen & ~addr_err;
   end

   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < 8; i++) begin
         byte_mask[i*8 +: 8] = {8{req_wmask[i]}};
      end
   end

   // Load data is taken from the registers as they stand before this cycle's tick or store.
   always_comb begin
      read_data = '0;
      if (sel_cmp) begin
         read_data = mtimecmp;
      end else if (sel_time) begin
         read_data = mtime;
      end
`ifdef CLINT_MSIP_EN
      else if (sel_msip) begin
         read_data = {63'd0, msip};
      end
`endif
   end

   // A store to mtime replaces the tick increment in the same cycle; the prescaler keeps running.
   always_comb begin
      tick           = (prescaler == PRE_LAST);
      prescaler_next = tick ? '0 : prescaler + PRE_W'(1);
      mtime_next     = tick ? mtime + 64'd1 : mtime;
      mtimecmp_next  = mtimecmp;
      if (do_write && sel_time) begin
         mtime_next = (mtime & ~byte_mask) | (req_wdata & byte_mask);
      end
      if (do_write && sel_cmp) begin
         mtimecmp_next = (mtimecmp & ~byte_mask) | (req_wdata & byte_mask);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mtime                 <= '0;
         mtimecmp              <= '1;
         prescaler             <= '0;
         resp_valid            <= 1'b0;
         resp_rdata            <= '0;
         resp_err              <= 1'b0;
         mtime_bigger_mtimecmp <= 1'b0;
      end else begin
         mtime                 <= mtime_next;
         mtimecmp              <= mtimecmp_next;
         prescaler             <= prescaler_next;
         mtime_bigger_mtimecmp <= (mtime >= mtimecmp);
         if (accept) begin
            resp_valid <= 1'b1;
            resp_rdata <= (req_wen || addr_err) ? 64'd0 : read_data;
            resp_err   <= addr_err;
         end else if (resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end

`ifdef CLINT_MSIP_EN
   always_comb begin
      msip_next = msip;
      if (do_write && sel_msip && req_wmask[0]) begin
         msip_next = req_wdata[0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         msip <= 1'b0;
      end else begin
         msip <= msip_next;
      end
   end

   assign sw_interrupt = msip;
`else
   assign sw_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed table, hand sequences and random traffic against a cycle-count based model.
// Expected msip behaviour follows CLINT_MSIP_EN as seen by this compile.
module tb_clint_timer;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam int          TDIV = 1;
`ifdef CLINT_MSIP_EN
   localparam logic        MSIP_EXP = 1'b1;
`else
   localparam logic        MSIP_EXP = 1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mtime_bigger_mtimecmp;
   logic        sw_interrupt;

   clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(TDIV)) dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_wen(req_wen),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_wmask(req_wmask),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mtime_bigger_mtimecmp(mtime_bigger_mtimecmp),
      .sw_interrupt(sw_interrupt)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } resp_t;

   typedef struct {
      logic        wen;
      logic [63:0] off;
      logic [63:0] wdata;
      logic [7:0]  mask;
      logic [63:0] exp_rdata;
      logic        exp_err;
      logic        exp_sw;
   } vec_t;

   int          total;
   int          bad;
   longint      cyc;
   resp_t       q[$];

   // Model: mtime is an anchor value plus the ticks elapsed since the anchor edge; ticks land on edges that are multiples of TDIV.
   logic [63:0] mv, mv_old, cmp_now, cmp_old;
   longint      mw, mw_old, cmp_w;
   logic        msip_m;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [63:0] mtimeAt(input longint x);
      if (x >= mw) return mv + 64'(x / TDIV - mw / TDIV);
      return mv_old + 64'(x / TDIV - mw_old / TDIV);
   endfunction

   function automatic logic [63:0] cmpAt(input longint x);
      return (x >= cmp_w) ? cmp_now : cmp_old;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic resetModel();
      q.delete();
      mv = '0; mv_old = '0; mw = 0; mw_old = 0;
      cmp_now = '1; cmp_old = '1; cmp_w = 0;
      msip_m = 1'b0;
   endtask

   task automatic idleInputs();
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wmask  = '0;
      resp_ready = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b0;
      idleInputs();
      resetModel();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic checkOutput();
      logic exp_big;
      check("resp_valid", resp_valid, q.size() != 0);
      if (q.size() != 0 && resp_valid) begin
         check("resp_rdata", resp_rdata, q[0].rdata);
         check("resp_err", resp_err, q[0].err);
      end
      exp_big = (cyc == 0) ? 1'b0 : (mtimeAt(cyc - 1) >= cmpAt(cyc - 1));
      check("mtime_bigger_mtimecmp", mtime_bigger_mtimecmp, exp_big);
      check("sw_interrupt", sw_interrupt, msip_m);
   endtask

   // One clock: check the present outputs, drive a request, update the model for the coming edge.
   task automatic applyStimulus(input logic v, input logic wen, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] mask, input logic rr);
      longint      e;
      logic [63:0] off;
      logic        err, acc, cons;
      resp_t       r;
      checkOutput();
      req_valid = v; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = mask; resp_ready = rr;
      #1;
      check("req_ready", req_ready, (q.size() == 0) || rr);
      e    = cyc + 1;
      acc  = v & req_ready;
      cons = resp_valid & rr;
      if (cons && q.size() != 0) void'(q.pop_front());
      if (acc) begin
         off = addr - BASE;
         err = (addr[2:0] != 3'd0) || !(off == 64'h0 || off == 64'h4000 || off == 64'hBFF8);
         r.err   = err;
         r.rdata = '0;
         if (!err && !wen) begin
            if (off == 64'h4000)      r.rdata = cmp_now;
            else if (off == 64'hBFF8) r.rdata = mtimeAt(e - 1);
            else                      r.rdata = {63'd0, msip_m};
         end
         if (!err && wen) begin
            if (off == 64'h4000) begin
               cmp_old = cmp_now;
               cmp_now = merge(cmp_now, wdata, mask);
               cmp_w   = e;
            end else if (off == 64'hBFF8) begin
               logic [63:0] base_val;
               base_val = mtimeAt(e - 1);
               mv_old = mv; mw_old = mw;
               mv = merge(base_val, wdata, mask);
               mw = e;
            end else begin
`ifdef CLINT_MSIP_EN
               if (mask[0]) msip_m = wdata[0];
`endif
            end
         end
         q.push_back(r);
      end
      @(posedge clock);
      #1;
      idleInputs();
      @(negedge clock);
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 8'h00, 1'b1);
   endtask

   vec_t vecs[15];

   initial begin
      logic [63:0] held;
      total = 0;
      bad   = 0;
      reset = 1'b0;
      idleInputs();
      resetModel();

      vecs[0]  = '{1'b0, 64'h0008, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 64'hBFFC, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 64'h4000, 64'h55, 8'hFF, 64'h0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 64'h4000, 64'h0, 8'h00, 64'h55, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 64'h4000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h02, 64'h0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 64'h4000, 64'h0, 8'h00, 64'hAA55, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 64'h4000, 64'h1111_2222_3333_4444, 8'h00, 64'h0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 64'h4000, 64'h0, 8'h00, 64'hAA55, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 64'h4008, 64'h77, 8'hFF, 64'h0, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 64'h4004, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 64'h0000, 64'h0, 8'h00, 64'h0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 64'h0000, 64'h1, 8'h01, 64'h0, 1'b0, MSIP_EXP};
      vecs[12] = '{1'b0, 64'h0000, 64'h0, 8'h00, {63'd0, MSIP_EXP}, 1'b0, MSIP_EXP};
      vecs[13] = '{1'b1, 64'h0000, 64'h0, 8'h01, 64'h0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 64'h1_0000, 64'h0, 8'h00, 64'h0, 1'b1, 1'b0};

      @(negedge clock);
      doReset();

      // mtime counts from reset release; the load accepted on the 11th edge sees 10.
      repeat (10) idleCycle();
      applyStimulus(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b1);
      check("t1_mtime", resp_rdata, 64'd10);
      check("t1_big", mtime_bigger_mtimecmp, 1'b0);

      // Compare rises one cycle after mtime reaches mtimecmp and falls one cycle after re-arm.
      applyStimulus(1'b1, 1'b1, BASE + 64'h4000, 64'd20, 8'hFF, 1'b1);
      repeat (15) idleCycle();
      check("t2_high", mtime_bigger_mtimecmp, 1'b1);
      applyStimulus(1'b1, 1'b1, BASE + 64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
      check("t2_lag", mtime_bigger_mtimecmp, 1'b1);
      idleCycle();
      check("t2_low", mtime_bigger_mtimecmp, 1'b0);

      // Wrap from all-ones, then a partial store onto zero with no tick on the write cycle.
      applyStimulus(1'b1, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1);
      idleCycle();
      idleCycle();
      applyStimulus(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b1);
      check("t3_wrap", resp_rdata, 64'd0);
      applyStimulus(1'b1, 1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1);
      idleCycle();
      idleCycle();
      applyStimulus(1'b1, 1'b1, BASE + 64'hBFF8, 64'h1234_5678_AABB_CCDD, 8'h0F, 1'b1);
      applyStimulus(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b1);
      check("t3_masked", resp_rdata, 64'h0000_0000_AABB_CCDD);

      // Backpressure: response held, request stalled, then back-to-back with no bubble.
      applyStimulus(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b1);
      held = resp_rdata;
      repeat (3) begin
         applyStimulus(1'b1, 1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b0);
         check("t4_hold_valid", resp_valid, 1'b1);
         check("t4_hold_rdata", resp_rdata, held);
      end
      applyStimulus(1'b1, 1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b1);
      check("t4_next_valid", resp_valid, 1'b1);
      check("t4_next_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

      // Directed table: decode errors, masked mtimecmp stores, msip.
      for (int i = 0; i < 15; i++) begin
         applyStimulus(1'b1, vecs[i].wen, BASE + vecs[i].off, vecs[i].wdata, vecs[i].mask, 1'b1);
         check($sformatf("vec%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), resp_err, vecs[i].exp_err);
         check($sformatf("vec%0d_sw", i), sw_interrupt, vecs[i].exp_sw);
      end
      check("t5_cmp_kept", dut.mtimecmp, 64'hAA55);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [63:0] a;
         case ($urandom_range(0, 7))
            0, 1:    a = BASE + 64'h4000;
            2, 3:    a = BASE + 64'hBFF8;
            4:       a = BASE;
            5:       a = BASE + 64'h0008;
            6:       a = BASE + 64'hBFFC;
            default: a = BASE + {48'd0, 16'($urandom)};
         endcase
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                       {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 3) != 0));
      end
      repeat (2) idleCycle();

      // Reset while a response is pending clears it at once.
      applyStimulus(1'b1, 1'b0, BASE + 64'hBFF8, 64'd0, 8'h00, 1'b0);
      check("t6_pending", resp_valid, 1'b1);
      reset = 1'b0;
      #1;
      check("t6_rst_valid", resp_valid, 1'b0);
      check("t6_rst_rdata", resp_rdata, 64'd0);
      check("t6_rst_err", resp_err, 1'b0);
      check("t6_rst_big", mtime_bigger_mtimecmp, 1'b0);
      check("t6_rst_sw", sw_interrupt, 1'b0);
      @(negedge clock);
      doReset();
      idleCycle();
      applyStimulus(1'b1, 1'b0, BASE + 64'h4000, 64'd0, 8'h00, 1'b1);
      check("t6_cmp_reset", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
      idleCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
Core-local timer (CLINT subset) that owns the machine timer registers mtime and mtimecmp and drives the CPU's mtime_bigger_mtimecmp input.
- Sits on the data-side memory-mapped bus beside the LSU.
- Accepts single-beat load/store requests with a valid/ready handshake.
- Returns a buffered one-deep response.
- Supplies the CSR unit's timer-pending condition, which sets mip.MTIP.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, base of the CLINT window
TICK_DIV, 1, clock cycles per mtime increment (>=1)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_wen  in  1  1 = store, 0 = load
req_addr  in  64  byte address, must be 8-byte aligned
req_wdata  in  64  store data
req_wmask  in  8  byte enables for stores
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid & resp_ready
resp_rdata  out  64  load data (0 for stores and errors)
resp_err  out  1  unmapped or misaligned access
mtime_bigger_mtimecmp  out  1  registered (mtime >= mtimecmp)
sw_interrupt  out  1  msip bit 0

Behaviour:
Reset (reset low, asynchronous) sets:
- mtime = 0; mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF; msip = 0; prescaler = 0
- resp_valid = 0; resp_rdata = 0; resp_err = 0
- mtime_bigger_mtimecmp = 0; sw_interrupt = 0
- Reset mid-transaction discards any pending response; no write takes effect.

Address map (offset from BASE_ADDR):
- 0x0000: msip (bit 0 only, other bits read 0)
- 0x4000: mtimecmp
- 0xBFF8: mtime
- Any other address, or req_addr[2:0] != 0: resp_err = 1, resp_rdata = 0, no state change.

Handshake:
- req_ready = ~resp_valid | resp_ready. One outstanding request at most.
- On accept, the response is registered next cycle: resp_valid = 1, with resp_rdata/resp_err.
- The response holds stable until resp_ready. resp_valid clears the cycle after consumption unless a new request is accepted in the same cycle.
- Load latency is 1 cycle. Load data is the register value in the accept cycle, before any tick in that cycle.
- Stores update registers at the accept edge. Byte lane i is written iff req_wmask[i]. wmask = 0 is a legal no-op that still responds.

Counter:
- prescaler counts 0..TICK_DIV-1.
- On the terminal count it wraps to 0 and mtime increments by 1.
- mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0.
- TICK_DIV = 1 increments mtime every cycle.
- A store to mtime in the same cycle as a tick wins: the masked result is stored, with no +1. prescaler is not reset by mtime writes.

Compare:
- mtime_bigger_mtimecmp is registered from an unsigned 64-bit compare of the current register values, so it lags any mtime/mtimecmp change by 1 cycle.
- It stays high while the condition holds. The CSR side clears its pending bit via handle_timer_intr; software re-arms by writing mtimecmp.
- sw_interrupt = msip[0], registered directly.

Optional Feature:
CLINT_MSIP_EN
- Defined: msip register exists at offset 0x0000, is writable through byte lane 0, and drives sw_interrupt.
- Undefined: offset 0x0000 stays mapped, reads 0 with resp_err = 0, writes are ignored, and sw_interrupt is tied to 0.

Test Plan:
1. Reset, then hold reset high with TICK_DIV = 1 for 10 cycles, then load 0xBFF8. Required: resp_rdata = 10 (count from reset release to accept cycle) and mtime_bigger_mtimecmp = 0.
2. Store mtimecmp = 20 with wmask = 8'hFF. Required: mtime_bigger_mtimecmp rises exactly 1 cycle after mtime reaches 20 and stays high. Then store mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF. Required: the output falls 1 cycle later.
3. Store mtime = 64'hFFFF_FFFF_FFFF_FFFE. Required: after 2 ticks mtime = 0. A store with wmask = 8'h0F, wdata = 64'h1234_5678_AABB_CCDD onto mtime = 0 yields 64'h0000_0000_AABB_CCDD, with no tick added on the write cycle.
4. Hold resp_ready = 0 for 3 cycles after a load. Required: resp_valid and resp_rdata stay stable and req_ready = 0. Raise resp_ready with a back-to-back request. Required: a new response appears the next cycle with no bubble.
5. Load 0x0008 and load 0xBFFC. Required: resp_err = 1, resp_rdata = 0, registers unchanged.
6. With CLINT_MSIP_EN defined, store 1 to 0x0000. Required: sw_interrupt = 1 next cycle. Undefined: sw_interrupt stays 0 and a read of 0x0000 returns 0. Assert reset low mid-response. Required: resp_valid = 0 immediately.
